piso_tx: RTL and testbench

Parallel-in serial-out transmitter, the upstream stage of the sipo deserializer. It accepts WIDE-bit words over a valid/ready handshake and emits them MSB-first, one bit per clk, on a serial line that feeds the deserializer's serial input. A one-word holding register allows back-to-back words to stream with no idle gap. A per-word frame strobe marks the first bit of each word.

---
 rtl/piso_tx_pkg.sv | 18 +
 rtl/piso_shreg.sv | 27 ++
 rtl/piso_tx.sv | 115 +++++++++++
 tb/tb_piso_tx.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/piso_tx_pkg.sv
// Shared definitions for the piso_tx serializer and its matching deserializer:
// default word width, counter sizing and the transmit state encoding.
package piso_tx_pkg;

    localparam int unsigned WIDE_DEFAULT  = 4;
    localparam int unsigned CNT_W_DEFAULT = $clog2(WIDE_DEFAULT);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit-counter width for a given word width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/piso_shreg.sv
// Loadable left-shift register with an MSB tap; load wins over shift.
module piso_shreg #(
    parameter int unsigned WIDE = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            shift,
    input  logic [WIDE-1:0] load_data,
    output logic            msb
);

    logic [WIDE-1:0] q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {q[WIDE-2:0], 1'b0};
        end
    end

    assign msb = q[WIDE-1];

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: MSB-first serial stream with a one-word
// holding register so consecutive words leave with no idle gap.
module piso_tx
    import piso_tx_pkg::*;
#(
    parameter int unsigned WIDE = WIDE_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [WIDE-1:0] din,
    input  logic            din_valid,
    output logic            din_ready,
    input  logic            abort,
    output logic            sout,
    output logic            sout_valid,
    output logic            frame,
    output logic            busy
);

    localparam int unsigned    CW      = cnt_width(WIDE);
    localparam logic [CW-1:0]  CNT_TOP = CW'(WIDE - 1);

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [WIDE-1:0] hold, hold_nx;
    logic            hold_full, hold_full_nx;
    logic            sh_load, sh_shift;
    logic [WIDE-1:0] sh_data;
    logic            msb;
    logic            accept;

    assign din_ready = ~hold_full;
    assign accept    = din_valid & din_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            hold      <= hold_nx;
            hold_full <= hold_full_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        hold_nx      = hold;
        hold_full_nx = hold_full;
        sh_load      = 1'b0;
        sh_shift     = 1'b0;
        sh_data      = din;
        if (abort) begin
            state_nx     = IDLE;
            cnt_nx       = '0;
            hold_full_nx = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        sh_load  = 1'b1;
                        cnt_nx   = CNT_TOP;
                        state_nx = SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == '0) begin
                        // Last bit: a held word reloads first; din_ready is low then,
                        // so a same-edge accept can only happen with the hold empty.
                        if (hold_full) begin
                            sh_load      = 1'b1;
                            sh_data      = hold;
                            cnt_nx       = CNT_TOP;
                            hold_full_nx = 1'b0;
                        end else if (accept) begin
                            sh_load = 1'b1;
                            cnt_nx  = CNT_TOP;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        sh_shift = 1'b1;
                        cnt_nx   = cnt - CW'(1);
                        if (accept) begin
                            hold_nx      = din;
                            hold_full_nx = 1'b1;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    piso_shreg #(
        .WIDE(WIDE)
    ) u_shreg (
        .clk      (clk),
        .reset    (reset),
        .load     (sh_load),
        .shift    (sh_shift),
        .load_data(sh_data),
        .msb      (msb)
    );

    assign sout_valid = (state == SHIFT);
    assign sout       = sout_valid & msb;
    assign frame      = sout_valid && (cnt == CNT_TOP);
    assign busy       = sout_valid | hold_full;

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: the driver queues the expected serial bits of
// every accepted word; a negedge monitor pops and compares what the DUT sends.
module tb_piso_tx;

    localparam int unsigned W = 4;

    typedef struct packed {
        logic b;
        logic f;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic         abort = 1'b0;
    logic         sout;
    logic         sout_valid;
    logic         frame;
    logic         busy;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic started = 1'b0;
    exp_t e;
    logic had;

    piso_tx #(
        .WIDE(W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .din       (din),
        .din_valid (din_valid),
        .din_ready (din_ready),
        .abort     (abort),
        .sout      (sout),
        .sout_valid(sout_valid),
        .frame     (frame),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Reference: each accepted word contributes WIDE bits, MSB first, frame on the
    // first. A word is accepted when fewer than WIDE bits remain queued beyond the
    // one currently on the line, i.e. the holding slot is empty.
    task automatic drive(input logic v, input logic [W-1:0] d, input logic ab, output logic acc);
        din       = d;
        din_valid = v;
        abort     = ab;
        @(posedge clk);
        acc = 1'b0;
        if (ab) begin
            sb.delete();
        end else if (v && sb.size() < W) begin
            acc = 1'b1;
            for (int i = W - 1; i >= 0; i--)
                sb.push_back('{b: d[i], f: (i == W - 1)});
        end
        #2;
        din_valid = 1'b0;
        abort     = 1'b0;
        din       = W'($urandom);
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) drive(1'b0, W'($urandom), 1'b0, a);
    endtask

    always @(negedge clk) begin
        if (started && reset) begin
            had = (sb.size() > 0);
            if (had) begin
                e = sb.pop_front();
                chk("sout_valid", sout_valid, 1'b1);
                chk("sout", sout, e.b);
                chk("frame", frame, e.f);
            end else begin
                chk("sout_valid_idle", sout_valid, 1'b0);
                chk("sout_idle", sout, 1'b0);
                chk("frame_idle", frame, 1'b0);
            end
            chk("din_ready", din_ready, sb.size() < W);
            chk("busy", busy, had);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        int   tries;
        repeat (2) @(negedge clk);
        chk("reset_sout_valid", sout_valid, 1'b0);
        chk("reset_din_ready", din_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 started = 1'b1;

        // single word, then back-to-back pair
        drive(1'b1, 4'b1011, 1'b0, a);
        idle(6);
        drive(1'b1, 4'b1100, 1'b0, a);
        drive(1'b1, 4'b0110, 1'b0, a);
        tries = 0;
        do begin
            drive(1'b1, 4'b1111, 1'b0, a);
            tries++;
        end while (!a && tries < 4 * W);
        chk("third_word_accepted", a, 1'b1);
        idle(3 * W);

        // abort during a word with another word held
        drive(1'b1, 4'b1010, 1'b0, a);
        drive(1'b1, 4'b0101, 1'b0, a);
        drive(1'b0, 4'b0000, 1'b0, a);
        drive(1'b1, 4'b0011, 1'b1, a);
        idle(W + 2);

        // asynchronous reset between edges mid-word
        drive(1'b1, 4'b1101, 1'b0, a);
        drive(1'b0, 4'b0000, 1'b0, a);
        #1 reset = 1'b0;
        #1;
        chk("async_rst_sout", sout, 1'b0);
        chk("async_rst_sout_valid", sout_valid, 1'b0);
        chk("async_rst_frame", frame, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        sb.delete();
        @(negedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2;
        drive(1'b1, 4'b1001, 1'b0, a);
        idle(W + 2);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 9) < 6, W'($urandom), $urandom_range(0, 39) == 0, a);
        end
        idle(2 * W + 2);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d bits left expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
